reg_file_32x32: RTL and testbench



---
 rtl/reg_file_32x32_if.sv | 28 ++
 rtl/reg_file_32x32.sv | 55 +++++
 tb/tb_reg_file_32x32.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_file_32x32_if.sv
// rtl/reg_file_32x32_if.sv - read/write port bundle for the 32x32 register file
//
// Purpose : groups the two read ports and the write port of reg_file_32x32.
// Signals : raddr1/raddr2 (5)  read addresses (rs / rt)
//           rdata1/rdata2 (32) combinational read data
//           we (1), waddr (5), wdata (32) write-back port
// Modports: master drives addresses/write port and samples read data;
//           slave is the register file itself.
`timescale 1ns/1ps
interface reg_file_32x32_if;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (
        output raddr1, raddr2, we, waddr, wdata,
        input  rdata1, rdata2
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - MIPS 32x32 general-purpose register file, $0 hardwired to zero
//
// Purpose : two combinational read ports, one clocked write port.
//           BYPASS=1 forwards wdata to a read of the address being written
//           in the same cycle; BYPASS=0 returns the stored (old) value.
// Ports   : clk  rising-edge clock
//           rst  synchronous reset, active-high; clears r1..r31 and forces
//                both read ports to zero while asserted
//           rf   reg_file_32x32_if.slave (read/write ports)
`timescale 1ns/1ps
module reg_file_32x32 #(
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_32x32_if.slave  rf
);

    // r0 has no storage; the array starts at index 1.
    logic [31:0] regs [1:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (rf.we && (rf.waddr != 5'd0)) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    // Per-port read priority: reset, then $0, then bypass, then the array.
    // The $0 check precedes the array lookup so index 0 is never used.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        data = 32'h0000_0000;
        if (rst || (addr == 5'd0)) begin
            data = 32'h0000_0000;
        end else if (BYPASS && rf.we && (addr == rf.waddr)) begin
            data = rf.wdata;
        end else begin
            data = regs[addr];
        end
        return data;
    endfunction

    always_comb begin
        rf.rdata1 = read_port(rf.raddr1);
    end

    always_comb begin
        rf.rdata2 = read_port(rf.raddr2);
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - self-checking bench for reg_file_32x32 (both BYPASS settings)
`timescale 1ns/1ps
module tb_reg_file_32x32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_32x32_if if_b ();
    reg_file_32x32_if if_n ();

    reg_file_32x32 #(.BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .rf(if_b.slave));
    reg_file_32x32 #(.BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .rf(if_n.slave));

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] eb1;
        logic [31:0] eb2;
        logic [31:0] en1;
        logic [31:0] en2;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    int vectors = 0;
    int miscompares = 0;

    // Architectural register contents as seen after the last edge.
    logic [31:0] model [32];

    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        rst = r;
        if_b.we = w;     if_n.we = w;
        if_b.waddr = wa; if_n.waddr = wa;
        if_b.wdata = wd; if_n.wdata = wd;
        if_b.raddr1 = a1; if_n.raddr1 = a1;
        if_b.raddr2 = a2; if_n.raddr2 = a2;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input bit byp, input logic r, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] a);
        if (r) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && w && (a == wa)) return wd;
        return model[a];
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [4:0] wa,
                              input logic [31:0] wd);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (w && (wa != 5'd0)) begin
            model[wa] = wd;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        //            rst   we    waddr  wdata          ra1    ra2    eb1            eb2            en1            en2
        tbl[0]  = '{1'b1, 1'b1, 5'd9,  32'hCAFEBABE, 5'd9,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0,         32'h0};
        tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h0,         32'h0,         32'h0,         32'h0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  32'h0,         32'h0,         32'h0,         32'h0};
        tbl[4]  = '{1'b0, 1'b1, 5'd1,  32'h12345678, 5'd1,  5'd31, 32'h12345678,  32'h0,         32'h0,         32'h0};
        tbl[5]  = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd1,  5'd31, 32'h12345678,  32'hFFFFFFFF,  32'h12345678,  32'h0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h12345678,  32'hFFFFFFFF,  32'h12345678,  32'hFFFFFFFF};
        tbl[7]  = '{1'b0, 1'b1, 5'd0,  32'hA5A5A5A5, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        tbl[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,         32'hFFFFFFFF,  32'h0,         32'hFFFFFFFF};
        tbl[9]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd1,  32'h11111111,  32'h12345678,  32'h0,         32'h12345678};
        tbl[10] = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222,  32'h22222222,  32'h11111111,  32'h11111111};
        tbl[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222,  32'h22222222,  32'h22222222,  32'h22222222};
        tbl[12] = '{1'b0, 1'b1, 5'd3,  32'hAAAAAAAA, 5'd3,  5'd3,  32'hAAAAAAAA,  32'hAAAAAAAA,  32'h0,         32'h0};
        tbl[13] = '{1'b0, 1'b1, 5'd3,  32'h55555555, 5'd3,  5'd3,  32'h55555555,  32'h55555555,  32'hAAAAAAAA,  32'hAAAAAAAA};
        tbl[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h55555555,  32'h55555555,  32'h55555555,  32'h55555555};

        @(posedge clk);
        #1;

        for (int k = 0; k < NVEC; k++) begin
            drive(tbl[k].rst, tbl[k].we, tbl[k].waddr, tbl[k].wdata, tbl[k].ra1, tbl[k].ra2);
            #2;
            check("tbl_byp_rdata1", k, if_b.rdata1, tbl[k].eb1);
            check("tbl_byp_rdata2", k, if_b.rdata2, tbl[k].eb2);
            check("tbl_nobyp_rdata1", k, if_n.rdata1, tbl[k].en1);
            check("tbl_nobyp_rdata2", k, if_n.rdata2, tbl[k].en2);
            model_edge(tbl[k].rst, tbl[k].we, tbl[k].waddr, tbl[k].wdata);
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 10000; k++) begin
            logic        r, w;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 63) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(r, w, wa, wd, a1, a2);
            #2;
            check("rnd_byp_rdata1", k, if_b.rdata1, exp_read(1'b1, r, w, wa, wd, a1));
            check("rnd_byp_rdata2", k, if_b.rdata2, exp_read(1'b1, r, w, wa, wd, a2));
            check("rnd_nobyp_rdata1", k, if_n.rdata1, exp_read(1'b0, r, w, wa, wd, a1));
            check("rnd_nobyp_rdata2", k, if_n.rdata2, exp_read(1'b0, r, w, wa, wd, a2));
            model_edge(r, w, wa, wd);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
